// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared constants and state encoding for the BCD converter
//
// Holds the values common to bin2bcd_seq and the downstream display driver:
// the digit width, the nibble used to blank the display on overflow, and the
// converter state encoding.
package bin2bcd_seq_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] OVF_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - combinational double-dabble digit correction
//
// Ports:
//   din  - one BCD digit of the accumulator before the shift
//   dout - din + 3 when din >= 5, otherwise din unchanged
module bcd_add3_digit
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // A valid digit is at most 9, so 9 + 3 = 12 still fits in four bits.
    assign dout = (din >= DIGIT_W'(5)) ? din + DIGIT_W'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter (one bit per clock)
//
// Ports:
//   CLK     - clock, rising edge
//   RESET_N - asynchronous active-low reset
//   START   - conversion request, only honoured in IDLE
//   BIN     - binary operand, captured on the accepting edge
//   BUSY    - high while a conversion is in flight
//   DONE    - one-cycle pulse in the cycle BCD/OVF take a new value
//   BCD     - packed BCD result, most significant digit in the top nibble
//   OVF     - last result needed more than OUT_DIGITS digits
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W      = 32,
    parameter int OUT_DIGITS = 8,
    parameter int ACC_DIGITS = 10
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          START,
    input  logic [BIN_W-1:0]              BIN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [DIGIT_W*OUT_DIGITS-1:0] BCD,
    output logic                          OVF
);

    localparam int ACC_W = DIGIT_W * ACC_DIGITS;
    localparam int OUT_W = DIGIT_W * OUT_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [BIN_W-1:0]         sh;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         acc_corr;
    logic [CNT_W-1:0]         cnt;
    logic [ACC_W+BIN_W-1:0]   shifted;
    logic                     last_shift;
    logic                     acc_ovf;

    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (acc[g*DIGIT_W +: DIGIT_W]),
            .dout (acc_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Correct first, then shift: the binary MSB enters the BCD LSB.
    assign shifted    = {acc_corr, sh} << 1;
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));
    assign acc_ovf    = |acc[ACC_W-1:OUT_W];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // BCD/OVF are written only in FIN so the display never sees a partial value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            BCD  <= '0;
            OVF  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        sh   <= BIN;
                        acc  <= '0;
                        cnt  <= '0;
                        BUSY <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc <= shifted[ACC_W+BIN_W-1:BIN_W];
                    sh  <= shifted[BIN_W-1:0];
                    cnt <= cnt + CNT_W'(1);
                end
                FIN: begin
                    OVF  <= acc_ovf;
                    BCD  <= acc_ovf ? {OUT_DIGITS{OVF_NIBBLE}} : acc[OUT_W-1:0];
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [31:0] BIN = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] BCD;
    logic        OVF;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    bin2bcd_seq #(.BIN_W(32), .OUT_DIGITS(8), .ACC_DIGITS(10)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .BIN     (BIN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .BCD     (BCD),
        .OVF     (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference conversion by decimal arithmetic: {ovf, bcd}.
    function automatic logic [32:0] ref_conv(input logic [31:0] v);
        logic [31:0] r;
        int unsigned x;
        if (v > 32'd99999999) return {1'b1, 32'hFFFFFFFF};
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {1'b0, r};
    endfunction

    // Transaction-level model: a conversion occupies 33 clocks after acceptance.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_bcd = '0;
    logic [31:0] m_op = '0;
    int          m_left = 0;

    always @(posedge CLK or negedge RESET_N) begin
        logic [32:0] r;
        if (!RESET_N) begin
            m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_bcd = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy && START) begin
                m_busy = 1'b1; m_left = 33; m_op = BIN;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    r = ref_conv(m_op);
                    m_busy = 1'b0; m_done = 1'b1; m_ovf = r[32]; m_bcd = r[31:0];
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en)
            check("model_cycle", {BUSY, DONE, OVF, BCD}, {m_busy, m_done, m_ovf, m_bcd});
    end

    task automatic run_conv(input logic [31:0] v, output int lat, output int busy_n);
        BIN = v; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; BIN = $urandom;
        lat = 0;
        busy_n = BUSY ? 1 : 0;
        while (!DONE && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            if (BUSY) busy_n++;
        end
    endtask

    task automatic conv_check(input string name, input logic [31:0] v,
                              input logic [31:0] exp_bcd, input logic exp_ovf);
        int lat, bn;
        run_conv(v, lat, bn);
        check({name, "_latency"}, lat, 33);
        check({name, "_bcd"}, BCD, exp_bcd);
        check({name, "_ovf"}, OVF, exp_ovf);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bn, cnt;
        logic [31:0] v;
        logic [32:0] r;

        // Reset
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b1;
        cmp_en = 1'b1;
        check("reset_bcd", BCD, 32'h0);
        check("reset_ovf", OVF, 1'b0);
        check("reset_busy", BUSY, 1'b0);
        check("reset_done", DONE, 1'b0);
        cnt = 0;
        repeat (100) begin @(posedge CLK); #1; if (DONE) cnt++; end
        check("idle_no_done", cnt, 0);

        // Zero and latency
        run_conv(32'h0, lat, bn);
        check("zero_latency", lat, 33);
        check("zero_busy_cycles", bn, 33);
        check("zero_bcd", BCD, 32'h0);
        check("zero_ovf", OVF, 1'b0);
        @(posedge CLK); #1;
        check("zero_done_single", DONE, 1'b0);

        // Nominal and boundary values
        conv_check("nominal", 32'h00BC614E, 32'h12345678, 1'b0);
        conv_check("max_fit", 32'h05F5E0FF, 32'h99999999, 1'b0);
        conv_check("first_ovf", 32'h05F5E100, 32'hFFFFFFFF, 1'b1);
        conv_check("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        conv_check("small", 32'h0000007B, 32'h00000123, 1'b0);

        // START pulses during a conversion are ignored
        BIN = 32'h05F5E0FF; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; BIN = $urandom;
        lat = 0;
        while (!DONE && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            START = (lat == 5 || lat == 20);
            if (START) BIN = $urandom;
        end
        START = 1'b0;
        check("ignore_latency", lat, 33);
        check("ignore_bcd", BCD, 32'h99999999);
        @(posedge CLK); #1;
        check("ignore_no_restart", BUSY, 1'b0);

        // START held through DONE: back-to-back, 34 clocks apart
        BIN = 32'h00BC614E; START = 1'b1;
        @(posedge CLK); #1;
        BIN = 32'h0000007B;
        lat = 0;
        while (!DONE && lat < 40) begin @(posedge CLK); #1; lat++; end
        check("held_first_latency", lat, 33);
        check("held_first_bcd", BCD, 32'h12345678);
        cnt = 0;
        do begin
            @(posedge CLK); #1;
            cnt++;
            if (cnt == 1) START = 1'b0;
        end while (!DONE && cnt < 40);
        check("held_done_spacing", cnt, 34);
        check("held_second_bcd", BCD, 32'h00000123);

        // Reset mid-conversion
        conv_check("pre_abort", 32'h00BC614E, 32'h12345678, 1'b0);
        BIN = 32'h0000007B; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #1 RESET_N = 1'b0;
        #1;
        check("abort_bcd", BCD, 32'h0);
        check("abort_busy", BUSY, 1'b0);
        check("abort_done", DONE, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        cnt = 0;
        repeat (40) begin @(posedge CLK); #1; if (DONE) cnt++; end
        check("abort_no_done", cnt, 0);
        conv_check("post_abort", 32'h0000007B, 32'h00000123, 1'b0);

        // Random regression, back-to-back
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom_range(0, 99999999);
                2:       v = 32'd99999998 + $urandom_range(0, 3);
                default: v = $urandom_range(0, 9999);
            endcase
            r = ref_conv(v);
            run_conv(v, lat, bn);
            check("rand_latency", lat, 33);
            check("rand_result", {OVF, BCD}, r);
        end

        repeat (3) @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
